// File: rtl/gfp8_group_encoder_if.sv
// Bundle of the element-input and packed-group-output handshakes of the GFP8 group encoder.
// Both sides are strict valid/ready: a beat transfers on any clock edge where valid and ready are
// both high; valid and its payload stay stable until that edge, and ready never waits on valid.
interface gfp8_group_encoder_if;
    logic         i_valid;
    logic         o_ready;
    logic [31:0]  i_mantissa;
    logic [7:0]   i_exponent;
    logic         o_valid;
    logic         i_ready;
    logic [7:0]   o_exp;
    logic [255:0] o_man;
    logic         o_sat;
    logic         o_unf;

    modport master (
        output i_valid, i_mantissa, i_exponent, i_ready,
        input  o_ready, o_valid, o_exp, o_man, o_sat, o_unf
    );

    modport slave (
        input  i_valid, i_mantissa, i_exponent, i_ready,
        output o_ready, o_valid, o_exp, o_man, o_sat, o_unf
    );
endinterface

// File: rtl/gfp8_group_encoder.sv
// Collects 32 scaled integers (m*2^e) and re-quantizes them into one GFP8 group: a shared
// biased 5-bit exponent plus 32 signed 8-bit mantissas rounded half away from zero.
module gfp8_group_encoder #(
    parameter int LANES    = 4,
    parameter int GROUP_ID = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    gfp8_group_encoder_if.slave  bus,
    output logic [1:0]           o_state,
    output logic [7:0]           o_group_id
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    localparam logic signed [9:0] TMAX_MIN = 10'sh200;
    localparam logic [5:0]        LANES6   = 6'(LANES);
    localparam logic [6:0]        LANES7   = 7'(LANES);

    logic [1:0]        state;
    logic [5:0]        count;
    logic signed [9:0] tmax;
    logic [39:0]       elem_buf [32];

    logic              valid_q;
    logic [7:0]        exp_q;
    logic [255:0]      man_q;
    logic              sat_q;
    logic              unf_q;

    function automatic logic [31:0] mag(input logic [31:0] m);
        return m[31] ? (~m + 32'd1) : m;
    endfunction

    function automatic logic [5:0] bitlen(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(i + 1);
        end
        return n;
    endfunction

    // One element {m[31:0], e[7:0]} scaled to the shared exponent xp, rounded and saturated.
    function automatic logic [7:0] requant(input logic [39:0] el, input logic signed [9:0] xp);
        logic [31:0]       a;
        logic signed [9:0] s;
        logic signed [9:0] ls;
        logic [32:0]       sum;
        logic [38:0]       wide;
        logic [6:0]        q;
        a    = mag(el[39:8]);
        s    = xp - {{2{el[7]}}, el[7:0]};
        ls   = '0;
        sum  = '0;
        wide = '0;
        q    = '0;
        if (s > 10'sd0) begin
            if (s < 10'sd33) begin
                sum = {1'b0, a} + (33'd1 << (s[5:0] - 6'd1));
                sum = sum >> s[5:0];
                q   = (sum > 33'd127) ? 7'd127 : sum[6:0];
            end
        end else begin
            ls = -s;
            if (ls >= 10'sd7) begin
                q = (a != 32'd0) ? 7'd127 : 7'd0;
            end else begin
                wide = {7'd0, a} << ls[2:0];
                q    = (wide > 39'd127) ? 7'd127 : wide[6:0];
            end
        end
        return el[39] ? -{1'b0, q} : {1'b0, q};
    endfunction

    logic [31:0]       in_mag;
    logic signed [9:0] t_in;
    assign in_mag = mag(bus.i_mantissa);
    assign t_in   = {{2{bus.i_exponent[7]}}, bus.i_exponent} + {4'd0, bitlen(in_mag)};

    // Shared exponent and clamp flags, derived from the running max during CONVERT.
    logic signed [9:0] b_val;
    logic signed [9:0] xp;
    logic [4:0]        exp_n;
    logic              sat_n;
    logic              unf_n;
    assign b_val = tmax + 10'sd8;

    always_comb begin
        exp_n = b_val[4:0];
        sat_n = 1'b0;
        unf_n = 1'b0;
        xp    = tmax - 10'sd7;
        if (tmax == TMAX_MIN) begin
            exp_n = 5'd0;
            xp    = 10'sd0;
        end else if (b_val > 10'sd31) begin
            exp_n = 5'd31;
            sat_n = 1'b1;
            xp    = 10'sd16;
        end else if (b_val < 10'sd0) begin
            exp_n = 5'd0;
            unf_n = 1'b1;
            xp    = -10'sd15;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_COLLECT;
            count   <= '0;
            tmax    <= TMAX_MIN;
            valid_q <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            sat_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (bus.i_valid) begin
                        if ((in_mag != 32'd0) && (t_in > tmax)) tmax <= t_in;
                        if (count == 6'd31) begin
                            count <= '0;
                            state <= S_CONVERT;
                        end else begin
                            count <= count + 6'd1;
                        end
                    end
                end
                S_CONVERT: begin
                    for (int l = 0; l < LANES; l++) begin
                        man_q[8*(32'(count) + l) +: 8] <= requant(elem_buf[5'(count + 6'(l))], xp);
                    end
                    if (({1'b0, count} + LANES7) == 7'd32) begin
                        count   <= '0;
                        valid_q <= 1'b1;
                        exp_q   <= {3'b000, exp_n};
                        sat_q   <= sat_n;
                        unf_q   <= unf_n;
                        state   <= S_OUTPUT;
                    end else begin
                        count <= count + LANES6;
                    end
                end
                S_OUTPUT: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        count   <= '0;
                        tmax    <= TMAX_MIN;
                        state   <= S_COLLECT;
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    // Element storage needs no reset: every slot is rewritten before a group is converted.
    always_ff @(posedge i_clk) begin
        if ((state == S_COLLECT) && bus.i_valid) begin
            elem_buf[count[4:0]] <= {bus.i_mantissa, bus.i_exponent};
        end
    end

    assign bus.o_ready = (state == S_COLLECT);
    assign bus.o_valid = valid_q;
    assign bus.o_exp   = exp_q;
    assign bus.o_man   = man_q;
    assign bus.o_sat   = sat_q;
    assign bus.o_unf   = unf_q;
    assign o_state     = state;
    assign o_group_id  = 8'(GROUP_ID);

endmodule

// File: tb/tb_gfp8_group_encoder.sv
// Scoreboard bench for gfp8_group_encoder: an arithmetic reference model predicts each packed group,
// which is queued when the elements are driven and compared when the group is offered.
module tb_gfp8_group_encoder;

    localparam int LANES = 4;
    localparam int W     = 266;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gfp8_group_encoder_if bus();
    logic [1:0] dbg_state;
    logic [7:0] dbg_gid;

    gfp8_group_encoder #(.LANES(LANES), .GROUP_ID(3)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .bus        (bus),
        .o_state    (dbg_state),
        .o_group_id (dbg_gid)
    );

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    int           gm[32];
    int           ge[32];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: {exp[7:0], man[255:0], sat, unf}
    function automatic logic [W-1:0] model();
        longint       a, q, tmp, tmax;
        int           bl, xp, b, s, v;
        bit           any;
        logic [7:0]   ex;
        logic [255:0] man;
        logic         sat, unf;
        any = 0; tmax = 0; man = '0; sat = 0; unf = 0; ex = 0; xp = 0;
        for (int k = 0; k < 32; k++) begin
            a = (gm[k] < 0) ? -longint'(gm[k]) : longint'(gm[k]);
            if (a != 0) begin
                bl = 0; tmp = a;
                while (tmp != 0) begin bl++; tmp = tmp >> 1; end
                if (!any || (ge[k] + bl > tmax)) tmax = ge[k] + bl;
                any = 1;
            end
        end
        if (any) begin
            b = int'(tmax) + 8;
            if (b > 31)     begin ex = 8'd31; sat = 1; xp = 16;  end
            else if (b < 0) begin ex = 8'd0;  unf = 1; xp = -15; end
            else            begin ex = 8'(b); xp = int'(tmax) - 7; end
        end
        for (int k = 0; k < 32; k++) begin
            a = (gm[k] < 0) ? -longint'(gm[k]) : longint'(gm[k]);
            s = xp - ge[k];
            if (s > 0)        q = (s >= 33) ? 0 : (a + (longint'(1) << (s - 1))) >> s;
            else if (-s >= 24) q = (a != 0) ? 128 : 0;
            else              q = a << (-s);
            if (q > 127) q = 127;
            v = (gm[k] < 0) ? -int'(q) : int'(q);
            man[8*k +: 8] = v[7:0];
        end
        return {ex, man, sat, unf};
    endfunction

    task automatic drive_elem(input int k);
        int guard;
        guard = 0;
        bus.i_valid    = 1'b1;
        bus.i_mantissa = gm[k];
        bus.i_exponent = 8'(ge[k]);
        while (!bus.o_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (guard >= 200) check("accept_timeout", 256'(guard), 256'(0));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic recv_group(input int stall);
        int           edges;
        logic [W-1:0] want;
        logic [255:0] snap_man;
        logic [7:0]   snap_exp;
        logic         snap_sat, snap_unf;
        edges = 0;
        while (!bus.o_valid && edges < 64) begin @(posedge clk); #1; edges++; end
        check("latency", 256'(edges), 256'(32 / LANES));
        want = exp_q.pop_front();
        if (!bus.o_valid) return;
        check("ready_low_out", 256'(bus.o_ready), 256'(0));
        snap_man = bus.o_man; snap_exp = bus.o_exp; snap_sat = bus.o_sat; snap_unf = bus.o_unf;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_man", bus.o_man, snap_man);
            check("stall_exp_flags", 256'({bus.o_exp, bus.o_sat, bus.o_unf, bus.o_valid, bus.o_ready}),
                  256'({snap_exp, snap_sat, snap_unf, 1'b1, 1'b0}));
        end
        check("o_exp", 256'(bus.o_exp), 256'(want[265:258]));
        check("o_man", bus.o_man, want[257:2]);
        check("o_sat", 256'(bus.o_sat), 256'(want[1]));
        check("o_unf", 256'(bus.o_unf), 256'(want[0]));
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        check("valid_drop", 256'(bus.o_valid), 256'(0));
        check("ready_back", 256'(bus.o_ready), 256'(1));
        check("hold_after", bus.o_man, snap_man);
    endtask

    task automatic run_group(input int stall);
        exp_q.push_back(model());
        for (int k = 0; k < 32; k++) drive_elem(k);
        recv_group(stall);
    endtask

    task automatic fill(input int m, input int e);
        for (int k = 0; k < 32; k++) begin gm[k] = m; ge[k] = e; end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"}, 256'({bus.o_valid, bus.o_ready, bus.o_sat, bus.o_unf, dbg_state}),
              256'({1'b0, 1'b1, 1'b0, 1'b0, 2'd0}));
        check({tag, "_exp"}, 256'(bus.o_exp), 256'(0));
        check({tag, "_man"}, bus.o_man, 256'(0));
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_mantissa = '0; bus.i_exponent = '0;
        #23;
        check_reset_values("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        fill(1, 0);                                   run_group(0);
        fill(1, 0); gm[0] = 1000;                     run_group(0);
        fill(0, 0); gm[0] = 255; gm[1] = -3;          run_group(0);

        // Abort a partial group with reset, then confirm stale elements are gone.
        fill(7, 20);
        for (int k = 0; k < 17; k++) drive_elem(k);
        rst_n = 1'b0; #1;
        check_reset_values("midreset");
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) begin gm[k] = int'($urandom_range(0, 4000)) - 2000; ge[k] = 0; end
        run_group(0);

        fill(127, 100);                               run_group(0);
        fill(1, -40);                                 run_group(0);
        fill(0, 0);                                   run_group(5);

        for (int k = 0; k < 32; k++) begin gm[k] = int'($urandom_range(0, 200)) - 100; ge[k] = int'($urandom_range(0, 6)) - 3; end
        gm[0] = int'(32'h8000_0000); ge[0] = 0;       run_group(2);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) begin
                gm[k] = int'($urandom());
                if ($urandom_range(0, 3) == 0) gm[k] = 0;
                ge[k] = int'($urandom_range(0, 40)) - 20;
            end
            run_group(int'($urandom_range(0, 3)));
        end

        check("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
